// File: rtl/hidden_ctrl_pkg.sv
// Shared types and default sizing for the hidden-layer control path.
// Holds the sequencer state encoding and the ASR layer default dimensions.
// Imported by the sequencer top and its counter helpers.
package hidden_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } hid_state_t;

  localparam int NUM_INPUTS_DEF = 39;
  localparam int NUM_HIDDEN_DEF = 16;
  localparam int PIPE_LAT_DEF   = 6;

endpackage

// File: rtl/tc_counter.sv
// Loadable up/down counter with a terminal-count flag.
// Latency: count updates on the clock edge after load/inc; tc is combinational from count.
// Load has priority over inc; with neither asserted the count holds.
module tc_counter #(
  parameter int WIDTH = 4,
  parameter int TERM  = 0,
  parameter bit DOWN  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERM);

  // Count register: load first, otherwise step in the configured direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= DOWN ? (count - WIDTH'(1)) : (count + WIDTH'(1));
    end
  end

  assign tc = (count == TERM_V);

endmodule

// File: rtl/hidden_layer_sequencer.sv
// Drives the shared MAC + tan-sigmoid datapath across every neuron of the hidden layer.
// Latency: INIT one cycle after an accepted start; per neuron NUM_INPUTS+PIPE_LAT+2 cycles.
// No backpressure: start is ignored while busy, abort returns to IDLE on the next cycle.
module hidden_layer_sequencer
  import hidden_ctrl_pkg::*;
#(
  parameter int NUM_INPUTS = NUM_INPUTS_DEF,
  parameter int NUM_HIDDEN = NUM_HIDDEN_DEF,
  parameter int PIPE_LAT   = PIPE_LAT_DEF,
  parameter int IN_AW      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  parameter int W_AW       = (NUM_INPUTS * NUM_HIDDEN > 1) ? $clog2(NUM_INPUTS * NUM_HIDDEN) : 1,
  parameter int H_AW       = (NUM_HIDDEN > 1) ? $clog2(NUM_HIDDEN) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            init_mac,
  output logic            ena_mac,
  output logic            ena_tagsigmoid,
  output logic [IN_AW-1:0] input_addr,
  output logic [W_AW-1:0]  weight_addr,
  output logic            out_wr_en,
  output logic [H_AW-1:0]  out_addr
);

  localparam int D_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  hid_state_t state, state_nxt;

  logic            start_ok;
  logic            i_tc, n_tc, d_tc;
  logic [H_AW-1:0] n_count;
  // Only the terminal flag of the drain counter steers the FSM.
  logic [D_W-1:0]  drain_count_unused;

  assign start_ok = (state == IDLE) && start && !abort;

  // Input index: cleared while in INIT, steps through MAC and parks on the last index.
  tc_counter #(.WIDTH(IN_AW), .TERM(NUM_INPUTS - 1), .DOWN(1'b0)) u_i_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     ((state == INIT) && !abort),
    .load_val ('0),
    .inc      ((state == MAC) && !i_tc && !abort),
    .count    (input_addr),
    .tc       (i_tc)
  );

  // Neuron index: cleared on start, advanced after each non-final write.
  tc_counter #(.WIDTH(H_AW), .TERM(NUM_HIDDEN - 1), .DOWN(1'b0)) u_n_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_ok),
    .load_val ('0),
    .inc      ((state == WRITE) && !n_tc && !abort),
    .count    (n_count),
    .tc       (n_tc)
  );

  // Drain timer: loaded as MAC finishes, counts the activation pipeline down to zero.
  tc_counter #(.WIDTH(D_W), .TERM(0), .DOWN(1'b1)) u_d_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     ((state == MAC) && i_tc && !abort),
    .load_val (D_W'(PIPE_LAT - 1)),
    .inc      ((state == DRAIN) && !d_tc && !abort),
    .count    (drain_count_unused),
    .tc       (d_tc)
  );

  // Running weight address: n*NUM_INPUTS+i without a multiplier. It parks on the last
  // address of a neuron and takes the extra step in the following INIT, so it holds
  // its value through DRAIN/WRITE and only wraps when the next start clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_addr <= '0;
    end else if (start_ok) begin
      weight_addr <= '0;
    end else if (!abort && (((state == MAC) && !i_tc) ||
                            ((state == INIT) && (n_count != '0)))) begin
      weight_addr <= weight_addr + W_AW'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = INIT;
      INIT:    state_nxt = MAC;
      MAC:     if (i_tc) state_nxt = DRAIN;
      DRAIN:   if (d_tc) state_nxt = WRITE;
      WRITE:   state_nxt = n_tc ? DONE : INIT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
    end
  end

  // Registered Moore outputs decoded from the state being entered, so they line up
  // with the state register; out_addr captures the neuron index only on WRITE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      init_mac       <= 1'b0;
      ena_mac        <= 1'b0;
      ena_tagsigmoid <= 1'b0;
      out_wr_en      <= 1'b0;
      out_addr       <= '0;
    end else begin
      busy           <= (state_nxt != IDLE);
      done           <= (state_nxt == DONE);
      init_mac       <= (state_nxt == INIT);
      ena_mac        <= (state_nxt == MAC);
      ena_tagsigmoid <= (state_nxt == DRAIN);
      out_wr_en      <= (state_nxt == WRITE);
      if (state_nxt == WRITE) begin
        out_addr <= n_count;
      end
    end
  end

endmodule

// File: tb/tb_hidden_layer_sequencer.sv
// Bench for hidden_layer_sequencer: two configurations checked cycle by cycle
// against a timeline model derived from the per-neuron period and phase.
module tb_hidden_layer_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Config A: NUM_INPUTS=4, NUM_HIDDEN=2, PIPE_LAT=6
  logic       a_start = 1'b0, a_abort = 1'b0;
  logic       a_busy, a_done, a_init, a_mac, a_ts, a_wr;
  logic [1:0] a_ia;
  logic [2:0] a_wa;
  logic [0:0] a_oa;

  // Config B: NUM_INPUTS=2, NUM_HIDDEN=1, PIPE_LAT=1
  logic       b_start = 1'b0, b_abort = 1'b0;
  logic       b_busy, b_done, b_init, b_mac, b_ts, b_wr;
  logic [0:0] b_ia;
  logic [0:0] b_wa;
  logic [0:0] b_oa;

  hidden_layer_sequencer #(.NUM_INPUTS(4), .NUM_HIDDEN(2), .PIPE_LAT(6)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
    .busy(a_busy), .done(a_done), .init_mac(a_init), .ena_mac(a_mac),
    .ena_tagsigmoid(a_ts), .input_addr(a_ia), .weight_addr(a_wa),
    .out_wr_en(a_wr), .out_addr(a_oa)
  );

  hidden_layer_sequencer #(.NUM_INPUTS(2), .NUM_HIDDEN(1), .PIPE_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
    .busy(b_busy), .done(b_done), .init_mac(b_init), .ena_mac(b_mac),
    .ena_tagsigmoid(b_ts), .input_addr(b_ia), .weight_addr(b_wa),
    .out_wr_en(b_wr), .out_addr(b_oa)
  );

  logic [53:0] obs_a, obs_b;
  assign obs_a = {a_busy, a_done, a_init, a_mac, a_ts, a_wr, 16'(a_ia), 16'(a_wa), 16'(a_oa)};
  assign obs_b = {b_busy, b_done, b_init, b_mac, b_ts, b_wr, 16'(b_ia), 16'(b_wa), 16'(b_oa)};

  int total = 0;
  int bad   = 0;

  // Reference model: per instance, whether a run is active and how many cycles since
  // its start edge; addresses are the last values shown during MAC/WRITE.
  int cfg_ni [2] = '{4, 2};
  int cfg_nh [2] = '{2, 1};
  int cfg_pl [2] = '{6, 1};
  bit m_act [2];
  int m_t   [2];
  int m_ia  [2];
  int m_wa  [2];
  int m_oa  [2];

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0; m_t[k] = 0; m_ia[k] = 0; m_wa[k] = 0; m_oa[k] = 0;
    end
  endtask

  task automatic model_edge(input int k, input bit st, input bit ab);
    int p, ph, nk;
    p = cfg_ni[k] + cfg_pl[k] + 2;
    if (ab) begin
      m_act[k] = 1'b0;
    end else if (m_act[k]) begin
      if (m_t[k] == cfg_nh[k] * p + 1) m_act[k] = 1'b0;
      else m_t[k] = m_t[k] + 1;
    end else if (st) begin
      m_act[k] = 1'b1; m_t[k] = 1; m_wa[k] = 0;
    end
    if (m_act[k] && m_t[k] <= cfg_nh[k] * p) begin
      ph = (m_t[k] - 1) % p;
      nk = (m_t[k] - 1) / p;
      if (ph >= 1 && ph <= cfg_ni[k]) begin
        m_ia[k] = ph - 1;
        m_wa[k] = nk * cfg_ni[k] + ph - 1;
      end
      if (ph == cfg_ni[k] + cfg_pl[k] + 1) m_oa[k] = nk;
    end
  endtask

  function automatic logic [53:0] exp_vec(input int k);
    int p, ph;
    logic bz, dn, in, mc, ts, wr;
    p = cfg_ni[k] + cfg_pl[k] + 2;
    bz = 0; dn = 0; in = 0; mc = 0; ts = 0; wr = 0;
    if (m_act[k]) begin
      bz = 1;
      if (m_t[k] == cfg_nh[k] * p + 1) begin
        dn = 1;
      end else begin
        ph = (m_t[k] - 1) % p;
        in = (ph == 0);
        mc = (ph >= 1) && (ph <= cfg_ni[k]);
        ts = (ph > cfg_ni[k]) && (ph <= cfg_ni[k] + cfg_pl[k]);
        wr = (ph == cfg_ni[k] + cfg_pl[k] + 1);
      end
    end
    return {bz, dn, in, mc, ts, wr, 16'(m_ia[k]), 16'(m_wa[k]), 16'(m_oa[k])};
  endfunction

  // Drive inputs for one clock, advance the model at the edge, return at the negedge.
  task automatic step(input bit sa, input bit aa, input bit sb, input bit ab);
    a_start = sa; a_abort = aa; b_start = sb; b_abort = ab;
    @(posedge clk);
    if (!rst_n) model_clear();
    else begin
      model_edge(0, sa, aa);
      model_edge(1, sb, ab);
    end
    @(negedge clk);
    a_start = 0; a_abort = 0; b_start = 0; b_abort = 0;
  endtask

  task automatic test_reset();
    model_clear();
    @(negedge clk);
    total++;
    if (obs_a !== 54'd0) begin bad++; $display("FAIL reset_a got=%h exp=0", obs_a); end
    total++;
    if (obs_b !== 54'd0) begin bad++; $display("FAIL reset_b got=%h exp=0", obs_b); end
    rst_n = 1'b1;
    step(0, 0, 0, 0);
  endtask

  task automatic test_nominal();
    int done_cyc = -1;
    step(1, 0, 0, 0);
    for (int c = 1; c <= 27; c++) begin
      total++;
      if (obs_a !== exp_vec(0)) begin
        bad++; $display("FAIL nominal cyc=%0d got=%h exp=%h", c, obs_a, exp_vec(0));
      end
      if (a_done && done_cyc < 0) done_cyc = c;
      if (c == 17) begin
        total++;
        if (a_wa !== 3'd7) begin bad++; $display("FAIL nominal_wa17 got=%0d exp=7", a_wa); end
      end
      step(0, 0, 0, 0);
    end
    total++;
    if (done_cyc !== 25) begin bad++; $display("FAIL nominal_done_cycle got=%0d exp=25", done_cyc); end
  endtask

  task automatic test_restart_pulse();
    int done_cyc = -1;
    int busy_gap = 0;
    step(1, 0, 0, 0);
    for (int c = 1; c <= 27; c++) begin
      total++;
      if (obs_a !== exp_vec(0)) begin
        bad++; $display("FAIL restart cyc=%0d got=%h exp=%h", c, obs_a, exp_vec(0));
      end
      if (a_done && done_cyc < 0) done_cyc = c;
      if (c <= 25 && !a_busy) busy_gap++;
      step((c == 8) || (c <= 24 && $urandom_range(0, 3) == 0), 0, 0, 0);
    end
    total++;
    if (done_cyc !== 25 || busy_gap !== 0) begin
      bad++; $display("FAIL restart_done got=%0d gaps=%0d exp=25 gaps=0", done_cyc, busy_gap);
    end
  endtask

  task automatic test_abort();
    int seen = 0;
    step(1, 0, 0, 0);
    for (int c = 1; c <= 10; c++) begin
      total++;
      if (obs_a !== exp_vec(0)) begin
        bad++; $display("FAIL abort cyc=%0d got=%h exp=%h", c, obs_a, exp_vec(0));
      end
      if (c >= 5 && (a_busy || a_wr || a_done)) seen++;
      step(0, (c == 4), 0, 0);
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL abort_quiet got=%0d exp=0", seen); end
    step(1, 0, 0, 0);
    for (int c = 1; c <= 6; c++) begin
      total++;
      if (obs_a !== exp_vec(0)) begin
        bad++; $display("FAIL abort_restart cyc=%0d got=%h exp=%h", c, obs_a, exp_vec(0));
      end
      if (c == 2) begin
        total++;
        if (a_wa !== 3'd0 || a_mac !== 1'b1) begin
          bad++; $display("FAIL abort_restart_wa got=%0d mac=%b exp=0 mac=1", a_wa, a_mac);
        end
      end
      step(0, 0, 0, 0);
    end
    step(0, 1, 0, 0);
  endtask

  task automatic test_start_abort();
    step(1, 1, 0, 0);
    for (int c = 1; c <= 3; c++) begin
      total++;
      if (a_busy !== 1'b0 || obs_a !== exp_vec(0)) begin
        bad++; $display("FAIL start_abort cyc=%0d got=%h exp=%h", c, obs_a, exp_vec(0));
      end
      step(0, 0, 0, 0);
    end
  endtask

  task automatic test_async_reset();
    step(1, 0, 0, 0);
    for (int c = 1; c <= 7; c++) step(0, 0, 0, 0);
    total++;
    if (a_ts !== 1'b1) begin bad++; $display("FAIL arst_in_drain got=%b exp=1", a_ts); end
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    total++;
    if (obs_a !== 54'd0) begin bad++; $display("FAIL arst_immediate got=%h exp=0", obs_a); end
    @(negedge clk);
    step(0, 0, 0, 0);
    total++;
    if (obs_a !== 54'd0) begin bad++; $display("FAIL arst_held got=%h exp=0", obs_a); end
    rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step(0, 0, 0, 0);
      total++;
      if (obs_a !== exp_vec(0)) begin
        bad++; $display("FAIL arst_idle cyc=%0d got=%h exp=%h", c, obs_a, exp_vec(0));
      end
    end
  endtask

  task automatic test_small_b();
    int done_cyc = -1;
    step(0, 0, 1, 0);
    for (int c = 1; c <= 16; c++) begin
      total++;
      if (obs_b !== exp_vec(1)) begin
        bad++; $display("FAIL small cyc=%0d got=%h exp=%h", c, obs_b, exp_vec(1));
      end
      if (b_done && done_cyc < 0) done_cyc = c;
      if (c == 8) begin
        total++;
        if (b_init !== 1'b1) begin bad++; $display("FAIL small_b2b got=%b exp=1", b_init); end
      end
      step(0, 0, (c == 7), 0);
    end
    total++;
    if (done_cyc !== 6) begin bad++; $display("FAIL small_done_cycle got=%0d exp=6", done_cyc); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 31) == 0);
      total++;
      if (obs_a !== exp_vec(0)) begin
        bad++; $display("FAIL random_a cyc=%0d got=%h exp=%h", c, obs_a, exp_vec(0));
      end
      total++;
      if (obs_b !== exp_vec(1)) begin
        bad++; $display("FAIL random_b cyc=%0d got=%h exp=%h", c, obs_b, exp_vec(1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_restart_pulse();
    test_abort();
    test_start_abort();
    test_async_reset();
    test_small_b();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
